// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the fetch PC, drives the instruction ROM and feeds decode through a 2-entry buffer.
// Define FETCH_PERF_EN to build the issued-fetch and stall-cycle counters; otherwise both ports read 0.
module instruction_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] instrAdd,
  input  logic [31:0]       instr,
  output logic [31:0]       instrOut,
  output logic [ADDR_W-1:0] pcOut,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectPC,
  input  logic              halt,
  output logic              halted,
  output logic [31:0]       perfFetchCnt,
  output logic [31:0]       perfStallCnt
);
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] HALTING = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0]       ins0_q, ins0_d, ins1_q, ins1_d;
  logic              pop, push, issue;
  logic [2:0]        occ;
  logic [1:0]        rem;
  // Credit check counts the in-flight fetch so a capture never finds the buffer full.
  always_comb begin
    pop           = (cnt_q != 2'd0) & instrReady & ~redirect;
    push          = inflight_q & ~redirect;
    occ           = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    issue         = (state_q == RUN) & ~halt & ~redirect & (occ < 3'd2);
    fetch_pc_d    = redirect ? redirectPC : issue ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    rem           = cnt_q - 2'(pop);
    cnt_d         = redirect ? 2'd0 : rem + 2'(push);
    pc0_d         = (push & rem == 2'd0) ? inflight_pc_q : pop ? pc1_q : pc0_q;
    ins0_d        = (push & rem == 2'd0) ? instr : pop ? ins1_q : ins0_q;
    pc1_d         = (push & rem == 2'd1) ? inflight_pc_q : pc1_q;
    ins1_d        = (push & rem == 2'd1) ? instr : ins1_q;
    state_d       = halt ? ((state_q == RUN & inflight_q & ~redirect) ? HALTING : HALTED) : RUN;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      cnt_q         <= 2'd0;
      pc0_q         <= '0;
      pc1_q         <= '0;
      ins0_q        <= '0;
      ins1_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      cnt_q         <= cnt_d;
      pc0_q         <= pc0_d;
      pc1_q         <= pc1_d;
      ins0_q        <= ins0_d;
      ins1_q        <= ins1_d;
    end
  end
  assign instrAdd   = fetch_pc_q;
  assign instrOut   = ins0_q;
  assign pcOut      = pc0_q;
  assign instrValid = cnt_q != 2'd0;
  assign halted     = state_q == HALTED;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(issue);
      stall_cnt_q <= stall_cnt_q + 32'(instrValid & ~instrReady);
    end
  end
  assign perfFetchCnt = fetch_cnt_q;
  assign perfStallCnt = stall_cnt_q;
`else
  assign perfFetchCnt = '0;
  assign perfStallCnt = '0;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector table, hand sequences and a randomized scoreboard run for the fetch unit.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrAdd, instr, instrOut, pcOut, redirectPC, perfFetchCnt, perfStallCnt;
  logic        instrValid, instrReady, redirect, halt, halted;
  int checks = 0;
  int failures = 0;
  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .instrAdd(instrAdd), .instr(instr), .instrOut(instrOut),
    .pcOut(pcOut), .instrValid(instrValid), .instrReady(instrReady), .redirect(redirect),
    .redirectPC(redirectPC), .halt(halt), .halted(halted),
    .perfFetchCnt(perfFetchCnt), .perfStallCnt(perfStallCnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) instr <= instrAdd ^ 32'hA5A5_0000;
  typedef struct {
    logic        rdy;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] add;
  } vec_t;
  vec_t tv[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [31:0] exp_next;
    logic        prev_redir, prev_halt;
    int          idle, n;
    rst = 1'b0; instrReady = 1'b0; redirect = 1'b0; redirectPC = '0; halt = 1'b0;
    // reset-release, backpressure and release, one row per clock edge
    tv[0]  = '{1'b1, 1'b0, 32'd0, 32'd1};
    tv[1]  = '{1'b1, 1'b1, 32'd0, 32'd2};
    tv[2]  = '{1'b1, 1'b1, 32'd1, 32'd3};
    tv[3]  = '{1'b1, 1'b1, 32'd2, 32'd4};
    for (int i = 4; i < 9; i++) tv[i] = '{1'b0, 1'b1, 32'd2, 32'd4};
    tv[9]  = '{1'b1, 1'b1, 32'd3, 32'd5};
    tv[10] = '{1'b1, 1'b1, 32'd4, 32'd6};
    tv[11] = '{1'b1, 1'b1, 32'd5, 32'd7};
    #12;
    chk("rst_valid", 32'(instrValid), 32'd0);
    chk("rst_pc", pcOut, 32'd0);
    chk("rst_instr", instrOut, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_add", instrAdd, 32'd0);
    chk("rst_perf_fetch", perfFetchCnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      instrReady = tv[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(instrValid), 32'(tv[i].vld));
      chk($sformatf("vec%0d_pc", i), pcOut, tv[i].pc);
      chk($sformatf("vec%0d_add", i), instrAdd, tv[i].add);
      if (tv[i].vld) chk($sformatf("vec%0d_instr", i), instrOut, tv[i].pc ^ 32'hA5A5_0000);
    end
`ifdef FETCH_PERF_EN
    chk("perf_stall", perfStallCnt, 32'd5);
    chk("perf_fetch", perfFetchCnt, 32'd7);
`else
    chk("perf_stall_off", perfStallCnt, 32'd0);
    chk("perf_fetch_off", perfFetchCnt, 32'd0);
`endif
    // redirect with a non-empty buffer and a fetch in flight
    instrReady = 1'b1;
    apply_reset();
    step(); step(); step();
    redirect = 1'b1; redirectPC = 32'h0000_0100;
    step();
    redirect = 1'b0;
    chk("redir_bubble0", 32'(instrValid), 32'd0);
    chk("redir_add", instrAdd, 32'h100);
    step();
    chk("redir_bubble1", 32'(instrValid), 32'd0);
    step();
    chk("redir_valid", 32'(instrValid), 32'd1);
    chk("redir_pc0", pcOut, 32'h100);
    chk("redir_instr0", instrOut, 32'hA5A5_0100);
    step();
    chk("redir_pc1", pcOut, 32'h101);
    // halt with a fetch in flight
    halt = 1'b1;
    step();
    chk("halting_not_halted", 32'(halted), 32'd0);
    chk("halting_delivers", pcOut, 32'h102);
    step();
    chk("halted_rise", 32'(halted), 32'd1);
    step(); step();
    chk("halted_hold", 32'(halted), 32'd1);
    chk("halted_add", instrAdd, 32'h103);
    halt = 1'b0;
    step();
    chk("unhalt", 32'(halted), 32'd0);
    n = 0;
    while (!instrValid && n < 8) begin
      step();
      n++;
    end
    chk("resume_valid", 32'(instrValid), 32'd1);
    chk("resume_pc", pcOut, 32'h103);
    // PC wrap-around
    redirect = 1'b1; redirectPC = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    step(); step();
    chk("wrap_valid", 32'(instrValid), 32'd1);
    chk("wrap_pc_hi", pcOut, 32'hFFFF_FFFF);
    step();
    chk("wrap_pc_lo", pcOut, 32'd0);
    chk("wrap_instr", instrOut, 32'hA5A5_0000);
    // async reset between clock edges
    #2;
    rst = 1'b0;
    #1;
    chk("areset_valid", 32'(instrValid), 32'd0);
    chk("areset_pc", pcOut, 32'd0);
    chk("areset_add", instrAdd, 32'd0);
    chk("areset_perf_fetch", perfFetchCnt, 32'd0);
    chk("areset_perf_stall", perfStallCnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(); step();
    chk("areset_restart_valid", 32'(instrValid), 32'd1);
    chk("areset_restart_pc", pcOut, 32'd0);
    // randomized run against an in-order delivery scoreboard
    apply_reset();
    exp_next = 32'd0; prev_redir = 1'b0; prev_halt = 1'b0; idle = 0;
    step();
    for (int c = 0; c < 3000; c++) begin
      if (prev_redir) chk("rnd_redir_bubble", 32'(instrValid), 32'd0);
      chk("rnd_halted_needs_halt", 32'(halted & ~prev_halt), 32'd0);
      redirect = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: redirectPC = 32'hFFFF_FFFE;
        1: redirectPC = 32'hFFFF_FFFF;
        default: redirectPC = $urandom;
      endcase
      instrReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) halt = ~halt;
      if (redirect) exp_next = redirectPC;
      else if (instrValid && instrReady) begin
        chk("rnd_pc", pcOut, exp_next);
        chk("rnd_instr", instrOut, exp_next ^ 32'hA5A5_0000);
        exp_next = exp_next + 32'd1;
      end
      idle = (instrReady && !halt && !redirect && !instrValid) ? idle + 1 : 0;
      chk("rnd_liveness", 32'(idle > 4), 32'd0);
      prev_redir = redirect;
      prev_halt = halt;
      step();
    end
    redirect = 1'b0; halt = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
